// File: rtl/uart_rx_deserializer.sv
// UART receiver: 8N1 serial-to-parallel with oversampled start/bit-centre sampling.
// Define UART_RX_PARITY_EN to receive 8E1 frames and drive parity_err.
module uart_rx_deserializer #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned Div   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned DivW  = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned TickW = $clog2(OVERSAMPLE);

  localparam logic [DivW-1:0]  DivMax  = DivW'(Div - 1);
  localparam logic [TickW-1:0] HalfMax = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] FullMax = TickW'(OVERSAMPLE - 1);

  if (Div == 0) begin : g_div_check
    $error("uart_rx_deserializer: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
  end

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e           state_q, state_d;
  logic             rx_meta_q, rx_s;
  logic [DivW-1:0]  div_q, div_d;
  logic             tick, restart;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       byte_q, byte_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             armed_q, armed_d;
  logic             par_ok;
`ifdef UART_RX_PARITY_EN
  logic             par_bad_q, par_bad_d;
  logic             perr_q, perr_d;
`endif

  // Synchronizer presets to idle-high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s      <= rx_meta_q;
    end
  end

  assign tick  = (div_q == DivMax);
  assign div_d = (restart || tick) ? '0 : div_q + 1'b1;

`ifdef UART_RX_PARITY_EN
  assign par_ok = !par_bad_q;
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    byte_d     = byte_q;
    armed_d    = armed_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    restart    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d  = par_bad_q;
    perr_d     = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d    = StStart;
          tick_cnt_d = '0;
          restart    = 1'b1;
        end
      end
      StStart: begin
        if (tick) begin
          if (tick_cnt_q == HalfMax) begin
            tick_cnt_d = '0;
            bit_idx_d  = '0;
            state_d    = rx_s ? StIdle : StData;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (tick_cnt_q == FullMax) begin
            tick_cnt_d         = '0;
            shreg_d[bit_idx_q] = rx_s;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end else begin
              bit_idx_d = bit_idx_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (tick) begin
          if (tick_cnt_q == FullMax) begin
            tick_cnt_d = '0;
            // Even parity: data plus parity bit must hold an even count of ones.
            par_bad_d  = (^shreg_q) ^ rx_s;
            state_d    = StStop;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
`endif
      StStop: begin
        if (tick) begin
          if (tick_cnt_q == FullMax) begin
            tick_cnt_d = '0;
            state_d    = StIdle;
`ifdef UART_RX_PARITY_EN
            perr_d     = par_bad_q;
`endif
            if (!rx_s) begin
              ferr_d  = 1'b1;
              // Line still low (break): wait for it to go high before re-arming.
              armed_d = 1'b0;
            end else if (par_ok) begin
              valid_d = 1'b1;
              byte_d  = shreg_q;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      div_q      <= '0;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      byte_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      armed_q    <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      byte_q     <= byte_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      armed_q    <= armed_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= par_bad_d;
      perr_q     <= perr_d;
`endif
    end
  end

  assign byte_out  = byte_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: table of frames plus hand-written corner cases,
// with a pulse scoreboard. Honours UART_RX_PARITY_EN for the 8E1 build.
module tb_uart_rx_deserializer;

  localparam int unsigned BitClk = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] byte_out;
  logic       valid, frame_err, parity_err, busy;

  uart_rx_deserializer #(
    .CLK_FREQ  (3_686_400),
    .BAUD_RATE (115_200),
    .OVERSAMPLE(16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .byte_out  (byte_out),
    .valid     (valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // flags = {valid, frame_err, parity_err}
  typedef struct {
    logic [2:0] flags;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    int         gap;
    logic [2:0] exp_flags;
    logic [7:0] exp_byte;
  } vec_t;

  exp_t sbq[$];
  exp_t mon_e;
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_valid_cyc = -1;
  int   t0;
  logic [7:0] held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && (valid || frame_err || parity_err)) begin
      if (sbq.size() == 0) begin
        check("unexpected_pulse", {29'd0, valid, frame_err, parity_err}, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        check("pulse_flags", {29'd0, valid, frame_err, parity_err}, {29'd0, mon_e.flags});
        check("byte_out", {24'd0, byte_out}, {24'd0, mon_e.data});
      end
      if (valid) last_valid_cyc = cyc;
    end
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BitClk) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par === 1'bx) send_bit(1'b1);
`endif
    send_bit(stop);
  endtask

  task automatic expect_pulse(input logic [2:0] flags, input logic [7:0] d);
    exp_t e;
    e.flags = flags;
    e.data  = d;
    sbq.push_back(e);
  endtask

  initial begin
    vecs.push_back('{8'h00, 1'b0, 1'b1, 0, 3'b100, 8'h00});
    vecs.push_back('{8'hFF, 1'b0, 1'b1, 0, 3'b100, 8'hFF});
    vecs.push_back('{8'h3C, 1'b0, 1'b0, 2, 3'b010, 8'hFF});
    vecs.push_back('{8'h5A, 1'b0, 1'b1, 0, 3'b100, 8'h5A});
    vecs.push_back('{8'hC3, 1'b0, 1'b1, 1, 3'b100, 8'hC3});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{8'h07, 1'b1, 1'b1, 0, 3'b100, 8'h07});
    vecs.push_back('{8'h07, 1'b0, 1'b1, 1, 3'b001, 8'h07});
`endif

    rx    = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_byte_out", {24'd0, byte_out}, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_parity_err", {31'd0, parity_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Single frame with latency measurement from the start edge.
    t0 = cyc;
    expect_pulse(3'b100, 8'hA5);
    send_frame(8'hA5, 1'b0, 1'b1);
    send_bit(1'b1);
`ifdef UART_RX_PARITY_EN
    check("latency_ok", {31'd0, (last_valid_cyc - t0 >= 336) && (last_valid_cyc - t0 <= 340)}, 32'd1);
`else
    check("latency_ok", {31'd0, (last_valid_cyc - t0 >= 304) && (last_valid_cyc - t0 <= 308)}, 32'd1);
`endif
    check("byte_after_a5", {24'd0, byte_out}, 32'hA5);

    // Table: back-to-back frames, framing error, parity cases.
    for (int v = 0; v < vecs.size(); v++) begin
      expect_pulse(vecs[v].exp_flags, vecs[v].exp_byte);
      send_frame(vecs[v].data, vecs[v].par, vecs[v].stop);
      for (int g = 0; g < vecs[v].gap; g++) send_bit(1'b1);
    end
    send_bit(1'b1);
    held = vecs[vecs.size()-1].exp_byte;
    check("byte_held_after_table", {24'd0, byte_out}, {24'd0, held});

    // Short glitch: START must abort at half bit without any pulse.
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_busy_high", {31'd0, busy}, 32'd1);
    repeat (12) @(negedge clk);
    check("glitch_busy_low", {31'd0, busy}, 32'd0);
    send_bit(1'b1);

    // Break: one frame_err, no re-arm while the line stays low.
    expect_pulse(3'b010, held);
    rx = 1'b0;
    repeat (12 * BitClk) @(negedge clk);
    check("break_busy_low", {31'd0, busy}, 32'd0);
    send_bit(1'b1);
    send_bit(1'b1);
    expect_pulse(3'b100, 8'h5A);
    send_frame(8'h5A, 1'b0, 1'b1);
    send_bit(1'b1);

    // Reset during data bit 4 of 8'h55 aborts it silently.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0] ? 1'b0 : 1'b1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    check("mid_frame_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_byte_out", {24'd0, byte_out}, 32'd0);
    reset = 1'b1;
    repeat (2 * BitClk) @(negedge clk);
    expect_pulse(3'b100, 8'h81);
    send_frame(8'h81, 1'b0, 1'b1);
    send_bit(1'b1);

    for (int i = 0; i < 2000 && sbq.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sbq.size(), 32'd0);
    check("final_byte", {24'd0, byte_out}, 32'h81);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
